spw_timecode_gen: RTL and testbench
===================================

SPW_TIMECODE_GEN -- requirements
Module: spw_timecode_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, time-code register width (4..32).
REQ-002 SHALL have parameter TIME_W, default 6, width of the incrementing time field, occupying bits [TIME_W-1:0] (TIME_W <= DATA_W).
REQ-003 SHALL have parameter PERIOD_W, default 32, width of the periodic tick timer (8..32).
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1 bit: slave select.
REQ-008 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-009 SHALL have port writedata, input, 32 bits: write data.
REQ-010 SHALL have port readdata, output, 32 bits: read data, combinational, zero wait states.
REQ-011 SHALL have port out_port, output, DATA_W bits: current time code to the CODEC.
REQ-012 SHALL have port tick_req, output, 1 bit: time-code send request, level.
REQ-013 SHALL have port tick_ack, input, 1 bit: CODEC accepted out_port, one-cycle pulse.
REQ-014 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-015 Register map SHALL be: 0 DATA; 1 CTRL (bit0 auto_inc, bit1 per_en, bit2 irq_en); 2 PERIOD; 3 STATUS (bit0 pending, bit1 overrun, bit2 done).
REQ-016 A write is chipselect=1 and write_n=0; reads SHALL return the addressed register zero-extended, with reserved bits read as 0.
REQ-017 A DATA write SHALL load out_port <= writedata[DATA_W-1:0] and set pending on the next edge.
REQ-018 tick_req SHALL equal pending.
REQ-019 tick_ack while pending=1 SHALL clear pending and set done.
REQ-020 tick_ack while pending=0 SHALL be ignored.
REQ-021 The timer SHALL count down only while per_en=1 and PERIOD!=0.
REQ-022 When the timer reaches 0, it SHALL reload PERIOD and raise a one-cycle expiry; the expiry interval is PERIOD+1 cycles.
REQ-023 A PERIOD write, or a 0->1 transition of per_en, SHALL reload the timer with the new value.
REQ-024 Expiry with pending=0 SHALL set pending; if auto_inc=1 it SHALL also increment out_port[TIME_W-1:0] modulo 2^TIME_W, with upper bits unchanged.
REQ-025 Expiry with pending=1 SHALL set overrun and leave out_port and pending unchanged.
REQ-026 A DATA write while pending=1 SHALL update out_port, keep pending=1 and set overrun.
REQ-027 A DATA write and expiry in the same cycle: the write SHALL win and the expiry SHALL be discarded, with no increment and no overrun.
REQ-028 A DATA write or expiry in the same cycle as tick_ack: pending SHALL remain 1, done SHALL set and overrun SHALL NOT set.
REQ-029 STATUS writes SHALL be write-1-to-clear for overrun (bit1) and done (bit2); pending is read-only.
REQ-030 irq SHALL equal irq_en AND (done OR overrun), registered.

Reset
REQ-031 While reset_n=0, out_port, CTRL, PERIOD, timer, pending, overrun, done and irq SHALL all be 0, so tick_req=0.
REQ-032 Reset asserted mid-handshake SHALL drop tick_req immediately (asynchronously); a late tick_ack after release SHALL be ignored.

Structure
REQ-033 A shared package spw_timecode_pkg SHALL hold the register address constants and the CTRL/STATUS bit-index constants.
REQ-034 The down-counter with reload and expiry SHALL be a sub-module spw_tick_timer, parameterised by PERIOD_W.

Verification
REQ-035 Write DATA=0x2A, then tick_ack 3 cycles later -> out_port=0x2A; tick_req high for cycles 1..3 after the write, then low; STATUS=0x4.
REQ-036 PERIOD=9, CTRL=0x3, DATA=0x3F, tick_ack 1 cycle after each request -> requests every 10 cycles; out_port goes 0x3F->0x00->0x01 (6-bit wrap, bits 7:6 kept).
REQ-037 PERIOD=4, per_en=1, no tick_ack -> first expiry sets pending; second expiry sets overrun; out_port unchanged; STATUS=0x3.
REQ-038 DATA write coincident with expiry (auto_inc=1) -> out_port=writedata, no increment, overrun=0.
REQ-039 irq_en=1 with done=1 -> irq=1; write STATUS=0x4 -> irq=0 next cycle.
REQ-040 Assert reset_n=0 while tick_req=1 -> tick_req, out_port and irq go 0 immediately; tick_ack after release -> no change.

Source files
------------

// File: rtl/spw_timecode_pkg.sv
// SpaceWire time-code generator: register map and bit positions
// shared by the generator and its bench.
package spw_timecode_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_PERIOD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_AUTO_INC = 0;
    localparam int CTRL_PER_EN   = 1;
    localparam int CTRL_IRQ_EN   = 2;

    localparam int STAT_PENDING = 0;
    localparam int STAT_OVERRUN = 1;
    localparam int STAT_DONE    = 2;

endpackage

// File: rtl/spw_tick_timer.sv
// Periodic down-counter: reloads on zero and flags a one-cycle expiry,
// giving an interval of period+1 cycles.
module spw_tick_timer #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_en,
    input  logic                i_load,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_expire
);

    logic [PERIOD_W-1:0] r_cnt;

    assign o_expire = i_en & ~i_load & (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_period;
        end else if (i_en) begin
            if (r_cnt == '0) r_cnt <= i_period;
            else             r_cnt <= r_cnt - PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/spw_timecode_gen.sv
// Avalon-MM time-code generator: holds the outgoing time code, raises
// send requests on writes or timer expiry, and tracks done/overrun.
module spw_timecode_gen
    import spw_timecode_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TIME_W   = 6,
    parameter int PERIOD_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              tick_req,
    input  logic              tick_ack,
    output logic              irq
);

    localparam logic [DATA_W-1:0] TMASK =
        DATA_W'((64'd1 << TIME_W) - 64'd1);

    logic [DATA_W-1:0]   r_out;
    logic                r_auto;
    logic                r_per_en;
    logic                r_irq_en;
    logic [PERIOD_W-1:0] r_period;
    logic                r_pending;
    logic                r_overrun;
    logic                r_done;
    logic                r_irq;

    logic w_wr, w_wr_data, w_wr_ctrl, w_wr_period, w_wr_status;
    logic w_tmr_exp, w_tmr_load, w_tmr_en, w_exp;
    logic w_ack, w_pend_eff, w_per_rise;
    logic w_pending_nx, w_ovr_nx, w_done_nx, w_irq_en_nx;
    logic [PERIOD_W-1:0] w_tmr_val;
    logic [DATA_W-1:0]   w_out_inc, w_out_nx;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_data   = w_wr & (address == ADDR_DATA);
    assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
    assign w_wr_period = w_wr & (address == ADDR_PERIOD);
    assign w_wr_status = w_wr & (address == ADDR_STATUS);

    assign w_per_rise = w_wr_ctrl & writedata[CTRL_PER_EN] & ~r_per_en;
    assign w_tmr_load = w_wr_period | w_per_rise;
    assign w_tmr_val  = w_wr_period ? writedata[PERIOD_W-1:0] : r_period;
    assign w_tmr_en   = r_per_en & (r_period != '0);

    spw_tick_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_en     (w_tmr_en),
        .i_load   (w_tmr_load),
        .i_period (w_tmr_val),
        .o_expire (w_tmr_exp)
    );

    // An ack in the same cycle frees the slot, so a new request then
    // counts as fresh rather than as an overrun.
    assign w_ack      = r_pending & tick_ack;
    assign w_pend_eff = r_pending & ~tick_ack;
    assign w_exp      = w_tmr_exp & ~w_wr_data;

    assign w_out_inc = (r_out & ~TMASK) | ((r_out + DATA_W'(1)) & TMASK);

    always_comb begin
        w_out_nx = r_out;
        if (w_wr_data)
            w_out_nx = writedata[DATA_W-1:0];
        else if (w_exp & ~w_pend_eff & r_auto)
            w_out_nx = w_out_inc;
    end

    assign w_pending_nx = w_wr_data | w_exp | w_pend_eff;
    assign w_ovr_nx = (r_overrun & ~(w_wr_status & writedata[STAT_OVERRUN]))
                    | ((w_wr_data | w_exp) & w_pend_eff);
    assign w_done_nx = (r_done & ~(w_wr_status & writedata[STAT_DONE]))
                     | w_ack;
    assign w_irq_en_nx = w_wr_ctrl ? writedata[CTRL_IRQ_EN] : r_irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out     <= '0;
            r_auto    <= 1'b0;
            r_per_en  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_period  <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_done    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_out     <= w_out_nx;
            r_irq_en  <= w_irq_en_nx;
            r_pending <= w_pending_nx;
            r_overrun <= w_ovr_nx;
            r_done    <= w_done_nx;
            r_irq     <= w_irq_en_nx & (w_done_nx | w_ovr_nx);
            if (w_wr_ctrl) begin
                r_auto   <= writedata[CTRL_AUTO_INC];
                r_per_en <= writedata[CTRL_PER_EN];
            end
            if (w_wr_period) r_period <= writedata[PERIOD_W-1:0];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(r_out);
            ADDR_CTRL:   readdata = {29'd0, r_irq_en, r_per_en, r_auto};
            ADDR_PERIOD: readdata = 32'(r_period);
            default:     readdata = {29'd0, r_done, r_overrun, r_pending};
        endcase
    end

    assign out_port = r_out;
    assign tick_req = r_pending;
    assign irq      = r_irq;

endmodule

// File: tb/tb_spw_timecode_gen.sv
// Directed bench for spw_timecode_gen with an expectation queue.
module tb_spw_timecode_gen;
    import spw_timecode_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        tick_req;
    logic        tick_ack;
    logic        irq;

    spw_timecode_gen #(.DATA_W(8), .TIME_W(6), .PERIOD_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .tick_req   (tick_req),
        .tick_ack   (tick_ack),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sbq.size() == 0) begin
            $error("FAIL sb_empty observed=0x%0h expected=none", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s observed=0x%0h expected=0x%0h",
                        e.tag, obs, e.val);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic ack();
        tick_ack = 1'b1;
        @(negedge clk);
        tick_ack = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_req(output int t);
        t = -1;
        for (int i = 0; i < 40 && t < 0; i++) begin
            if (tick_req === 1'b1) t = cyc;
            else @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int t1, t2;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        tick_ack   = 1'b0;

        // reset state
        #2;
        push("rst_out", 0); push("rst_req", 0); push("rst_irq", 0);
        push("rst_ctrl", 0); push("rst_period", 0); push("rst_status", 0);
        chk(32'(out_port)); chk(32'(tick_req)); chk(32'(irq));
        rd(ADDR_CTRL, d);   chk(d);
        rd(ADDR_PERIOD, d); chk(d);
        rd(ADDR_STATUS, d); chk(d);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // manual request, ack three cycles later
        wr(ADDR_DATA, 32'h2A);
        push("m_req_c1", 1); push("m_out", 32'h2A);
        chk(32'(tick_req)); chk(32'(out_port));
        @(negedge clk);
        push("m_req_c2", 1); chk(32'(tick_req));
        @(negedge clk);
        push("m_req_c3", 1); chk(32'(tick_req));
        ack();
        push("m_req_c4", 0); push("m_status", 32'h4); push("m_rd_data", 32'h2A);
        chk(32'(tick_req));
        rd(ADDR_STATUS, d); chk(d);
        rd(ADDR_DATA, d);   chk(d);
        wr(ADDR_STATUS, 32'h4);
        push("m_status_clr", 0);
        rd(ADDR_STATUS, d); chk(d);

        // periodic auto-increment with 6-bit wrap
        wr(ADDR_PERIOD, 32'd9);
        wr(ADDR_CTRL, 32'h3);
        wr(ADDR_DATA, 32'h3F);
        push("p_req0", 1); push("p_out0", 32'h3F);
        chk(32'(tick_req)); chk(32'(out_port));
        ack();
        wait_req(t1);
        push("p_seen1", 1); push("p_out1", 32'h00);
        chk(32'(t1 >= 0)); chk(32'(out_port));
        ack();
        wait_req(t2);
        push("p_seen2", 1); push("p_out2", 32'h01); push("p_gap", 32'd10);
        chk(32'(t2 >= 0)); chk(32'(out_port)); chk(32'(t2 - t1));
        ack();
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_STATUS, 32'h6);

        // overrun on second expiry without ack
        wr(ADDR_PERIOD, 32'd4);
        wr(ADDR_CTRL, 32'h2);
        repeat (4) @(negedge clk);
        push("o_req_early", 0); chk(32'(tick_req));
        @(negedge clk);
        push("o_status1", 32'h1); push("o_req1", 1);
        rd(ADDR_STATUS, d); chk(d); chk(32'(tick_req));
        repeat (5) @(negedge clk);
        push("o_status2", 32'h3); push("o_out", 32'h01);
        rd(ADDR_STATUS, d); chk(d); chk(32'(out_port));
        wr(ADDR_CTRL, 32'h0);
        ack();
        wr(ADDR_STATUS, 32'h6);

        // data write coincident with expiry
        wr(ADDR_PERIOD, 32'd4);
        wr(ADDR_CTRL, 32'h3);
        repeat (4) @(negedge clk);
        wr(ADDR_DATA, 32'h15);
        push("c_out", 32'h15); push("c_status", 32'h1);
        chk(32'(out_port));
        rd(ADDR_STATUS, d); chk(d);
        wr(ADDR_CTRL, 32'h0);
        ack();
        wr(ADDR_STATUS, 32'h6);
        push("c_status_clr", 0);
        rd(ADDR_STATUS, d); chk(d);

        // interrupt on done, cleared by write-1
        wr(ADDR_CTRL, 32'h4);
        push("i_irq0", 0); chk(32'(irq));
        wr(ADDR_DATA, 32'h07);
        ack();
        push("i_irq1", 1); push("i_status", 32'h4);
        chk(32'(irq));
        rd(ADDR_STATUS, d); chk(d);
        wr(ADDR_STATUS, 32'h4);
        push("i_irq_clr", 0); chk(32'(irq));

        // reset in the middle of a handshake
        wr(ADDR_DATA, 32'h5A);
        wr(ADDR_DATA, 32'h5B);
        push("r_req_pre", 1); push("r_irq_pre", 1); push("r_out_pre", 32'h5B);
        chk(32'(tick_req)); chk(32'(irq)); chk(32'(out_port));
        #2 reset_n = 1'b0;
        #1;
        push("r_req_async", 0); push("r_out_async", 0); push("r_irq_async", 0);
        chk(32'(tick_req)); chk(32'(out_port)); chk(32'(irq));
        @(negedge clk);
        reset_n = 1'b1;
        ack();
        push("r_req_late", 0); push("r_out_late", 0); push("r_status_late", 0);
        chk(32'(tick_req)); chk(32'(out_port));
        rd(ADDR_STATUS, d); chk(d);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
